// File: rtl/mig_pkg.sv
// Shared MIG UI command encodings, data width and sequencer state types.
package mig_pkg;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;
  localparam int         MIG_DATA_W    = 128;

  typedef enum logic [1:0] {IDLE, WRITE, READ} seq_state_t;

  // Side that won the most recent arbitration.
  typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;

endpackage

// File: rtl/mig_read_credit.sv
// Counts reads issued to the MIG but not yet returned; gates new read grants.
module mig_read_credit
  import mig_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_issue,
  input  logic i_retire,
  output logic o_can_issue
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] r_count;

  // Saturating guards keep a misbehaving MIG from wrapping the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_issue && !i_retire && r_count != MAX_CNT) begin
      r_count <= r_count + 1'b1;
    end else if (!i_issue && i_retire && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_can_issue = (r_count < MAX_CNT);

endmodule

// File: rtl/mig_cmd_sequencer.sv
// Arbitrates write beats and read requests onto the MIG UI, one command per
// transaction, and registers read data back out as a valid-only stream.
module mig_cmd_sequencer
  import mig_pkg::*;
#(
  parameter int WORD_ADDR_W     = 17,
  parameter int APP_ADDR_W      = 27,
  parameter int ADDR_SHIFT      = 3,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   calib_complete_in,
  input  logic                   write_valid_in,
  output logic                   write_ready_out,
  input  logic [MIG_DATA_W-1:0]  write_data_in,
  input  logic                   write_tuser_in,
  input  logic [WORD_ADDR_W-1:0] write_addr_in,
  output logic                   write_incr_out,
  output logic                   write_calib_out,
  input  logic                   read_valid_in,
  output logic                   read_ready_out,
  input  logic                   read_tuser_in,
  input  logic [WORD_ADDR_W-1:0] read_addr_in,
  output logic                   read_incr_out,
  output logic                   read_calib_out,
  output logic [APP_ADDR_W-1:0]  app_addr_out,
  output logic [2:0]             app_cmd_out,
  output logic                   app_en_out,
  input  logic                   app_rdy_in,
  output logic [MIG_DATA_W-1:0]  app_wdf_data_out,
  output logic                   app_wdf_wren_out,
  output logic                   app_wdf_end_out,
  input  logic                   app_wdf_rdy_in,
  input  logic [MIG_DATA_W-1:0]  app_rd_data_in,
  input  logic                   app_rd_data_valid_in,
  output logic [MIG_DATA_W-1:0]  read_data_out,
  output logic                   read_data_valid_out
);

  seq_state_t              r_state;
  grant_t                  r_last_grant;
  logic                    r_app_en;
  logic                    r_wren;
  logic [2:0]              r_app_cmd;
  logic [APP_ADDR_W-1:0]   r_app_addr;
  logic [MIG_DATA_W-1:0]   r_wdata;
  logic [MIG_DATA_W-1:0]   r_rd_data;
  logic                    r_rd_valid;

  logic                    w_can_issue;
  logic                    w_wr_elig;
  logic                    w_rd_elig;
  logic                    w_grant_wr;
  logic                    w_grant_rd;
  logic                    w_rd_issue;
  logic [APP_ADDR_W-1:0]   w_wr_app_addr;
  logic [APP_ADDR_W-1:0]   w_rd_app_addr;

  assign w_wr_elig  = calib_complete_in & write_valid_in;
  assign w_rd_elig  = calib_complete_in & read_valid_in & w_can_issue;
  assign w_grant_wr = (r_state == IDLE) & w_wr_elig &
                      (!w_rd_elig | (r_last_grant == GRANT_READ));
  assign w_grant_rd = (r_state == IDLE) & w_rd_elig &
                      (!w_wr_elig | (r_last_grant == GRANT_WRITE));

  assign write_ready_out = w_grant_wr;
  assign read_ready_out  = w_grant_rd;
  assign write_incr_out  = w_grant_wr;
  assign write_calib_out = w_grant_wr & write_tuser_in;
  assign read_incr_out   = w_grant_rd;
  assign read_calib_out  = w_grant_rd & read_tuser_in;

  assign w_wr_app_addr = APP_ADDR_W'(write_addr_in) << ADDR_SHIFT;
  assign w_rd_app_addr = APP_ADDR_W'(read_addr_in) << ADDR_SHIFT;
  assign w_rd_issue    = (r_state == READ) & r_app_en & app_rdy_in;

  mig_read_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_issue    (w_rd_issue),
    .i_retire   (app_rd_data_valid_in),
    .o_can_issue(w_can_issue)
  );

  // In WRITE, r_app_en / r_wren double as the inverted cmd_done / data_done flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_READ;
      r_app_en     <= 1'b0;
      r_wren       <= 1'b0;
      r_app_cmd    <= MIG_CMD_WRITE;
      r_app_addr   <= '0;
      r_wdata      <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_data  <= app_rd_data_in;
      r_rd_valid <= app_rd_data_valid_in;
      case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            r_state      <= WRITE;
            r_last_grant <= GRANT_WRITE;
            r_app_addr   <= w_wr_app_addr;
            r_wdata      <= write_data_in;
            r_app_cmd    <= MIG_CMD_WRITE;
            r_app_en     <= 1'b1;
            r_wren       <= 1'b1;
          end else if (w_grant_rd) begin
            r_state      <= READ;
            r_last_grant <= GRANT_READ;
            r_app_addr   <= w_rd_app_addr;
            r_app_cmd    <= MIG_CMD_READ;
            r_app_en     <= 1'b1;
          end
        end
        WRITE: begin
          if (app_rdy_in) r_app_en <= 1'b0;
          if (app_wdf_rdy_in) r_wren <= 1'b0;
          if ((!r_app_en || app_rdy_in) && (!r_wren || app_wdf_rdy_in))
            r_state <= IDLE;
        end
        READ: begin
          if (app_rdy_in) begin
            r_app_en <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign app_addr_out        = r_app_addr;
  assign app_cmd_out         = r_app_cmd;
  assign app_en_out          = r_app_en;
  assign app_wdf_data_out    = r_wdata;
  assign app_wdf_wren_out    = r_wren;
  assign app_wdf_end_out     = r_wren;
  assign read_data_out       = r_rd_data;
  assign read_data_valid_out = r_rd_valid;

endmodule

// File: tb/tb_mig_cmd_sequencer.sv
// Directed scenarios plus randomized traffic against a transaction-level
// scoreboard of the MIG command sequencer.
module tb_mig_cmd_sequencer;

  localparam int MAXO = 16;
  localparam logic [16:0] WR_BASE = 17'h0;
  localparam logic [16:0] RD_BASE = 17'h100;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rst_in, calib_complete_in;
  logic         write_valid_in, write_ready_out, write_tuser_in;
  logic [127:0] write_data_in;
  logic [16:0]  write_addr_in, read_addr_in;
  logic         write_incr_out, write_calib_out;
  logic         read_valid_in, read_ready_out, read_tuser_in;
  logic         read_incr_out, read_calib_out;
  logic [26:0]  app_addr_out;
  logic [2:0]   app_cmd_out;
  logic         app_en_out, app_rdy_in;
  logic [127:0] app_wdf_data_out;
  logic         app_wdf_wren_out, app_wdf_end_out, app_wdf_rdy_in;
  logic [127:0] app_rd_data_in, read_data_out;
  logic         app_rd_data_valid_in, read_data_valid_out;

  // External word-address counters; base is presented while calib pulses.
  logic [16:0] wr_cnt, rd_cnt;
  assign write_addr_in = write_calib_out ? WR_BASE : wr_cnt;
  assign read_addr_in  = read_calib_out  ? RD_BASE : rd_cnt;

  mig_cmd_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .calib_complete_in(calib_complete_in),
    .write_valid_in(write_valid_in), .write_ready_out(write_ready_out),
    .write_data_in(write_data_in), .write_tuser_in(write_tuser_in),
    .write_addr_in(write_addr_in), .write_incr_out(write_incr_out),
    .write_calib_out(write_calib_out),
    .read_valid_in(read_valid_in), .read_ready_out(read_ready_out),
    .read_tuser_in(read_tuser_in), .read_addr_in(read_addr_in),
    .read_incr_out(read_incr_out), .read_calib_out(read_calib_out),
    .app_addr_out(app_addr_out), .app_cmd_out(app_cmd_out),
    .app_en_out(app_en_out), .app_rdy_in(app_rdy_in),
    .app_wdf_data_out(app_wdf_data_out), .app_wdf_wren_out(app_wdf_wren_out),
    .app_wdf_end_out(app_wdf_end_out), .app_wdf_rdy_in(app_wdf_rdy_in),
    .app_rd_data_in(app_rd_data_in), .app_rd_data_valid_in(app_rd_data_valid_in),
    .read_data_out(read_data_out), .read_data_valid_out(read_data_valid_out)
  );

  typedef struct {
    logic        rd;
    logic [26:0] addr;
  } cmd_t;

  cmd_t         cmd_q[$];
  logic [127:0] wd_q[$];
  int           n_cmp = 0, n_bad = 0;
  int           tb_out;
  logic         tb_last_rd;
  logic         exp_rv;
  logic [127:0] exp_rd;
  logic         stall_c, stall_d;
  logic [26:0]  st_addr;
  logic [2:0]   st_cmd;
  logic [127:0] st_data;
  logic         s_wincr, s_wcal, s_rincr, s_rcal;
  logic         rand_in, mig_auto;
  logic         ev_wacc, ev_racc;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_model();
    cmd_q.delete();
    wd_q.delete();
    tb_out = 0; tb_last_rd = 1'b1; exp_rv = 1'b0; exp_rd = '0;
    stall_c = 1'b0; stall_d = 1'b0;
    s_wincr = 1'b0; s_wcal = 1'b0; s_rincr = 1'b0; s_rcal = 1'b0;
  endtask

  // Observe one cycle at the negedge and score every handshake it will commit.
  task automatic sample();
    int   out_now;
    cmd_t c;
    @(negedge clk_in);
    out_now = tb_out;
    ev_wacc = write_valid_in & write_ready_out;
    ev_racc = read_valid_in & read_ready_out;
    if (write_ready_out | read_ready_out) begin
      chk("rdy_excl", write_ready_out & read_ready_out, 0);
      chk("rdy_calib", calib_complete_in, 1);
    end
    if (ev_wacc | write_incr_out | write_calib_out) begin
      chk("wincr", write_incr_out, ev_wacc);
      chk("wcal", write_calib_out, ev_wacc & write_tuser_in);
    end
    if (ev_racc | read_incr_out | read_calib_out) begin
      chk("rincr", read_incr_out, ev_racc);
      chk("rcal", read_calib_out, ev_racc & read_tuser_in);
    end
    if (stall_c) begin
      chk("hold_en", app_en_out, 1);
      chk("hold_addr", app_addr_out, st_addr);
      chk("hold_cmd", app_cmd_out, st_cmd);
    end
    if (stall_d) begin
      chk("hold_wren", app_wdf_wren_out, 1);
      chk("hold_wdata", app_wdf_data_out, st_data);
    end
    stall_c = app_en_out & !app_rdy_in;
    stall_d = app_wdf_wren_out & !app_wdf_rdy_in;
    st_addr = app_addr_out; st_cmd = app_cmd_out; st_data = app_wdf_data_out;
    if (app_wdf_wren_out | app_wdf_end_out) chk("wdf_end", app_wdf_end_out, app_wdf_wren_out);
    if (app_en_out & app_rdy_in) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
      else begin
        c = cmd_q.pop_front();
        chk("cmd", app_cmd_out, c.rd ? 3'b001 : 3'b000);
        chk("addr", app_addr_out, c.addr);
        if (c.rd) tb_out++;
      end
    end
    if (app_wdf_wren_out & app_wdf_rdy_in) begin
      if (wd_q.size() == 0) chk("wdata_unexpected", 1, 0);
      else chk("wdata", app_wdf_data_out, wd_q.pop_front());
    end
    if (ev_wacc | ev_racc) chk("one_in_flight", cmd_q.size() + wd_q.size(), 0);
    if (ev_wacc) begin
      if (read_valid_in && out_now < MAXO) chk("rr_w", tb_last_rd, 1);
      tb_last_rd = 1'b0;
      cmd_q.push_back('{1'b0, {10'b0, write_addr_in} * 27'd8});
      wd_q.push_back(write_data_in);
    end
    if (ev_racc) begin
      chk("credit", out_now < MAXO, 1);
      if (write_valid_in) chk("rr_r", tb_last_rd, 0);
      tb_last_rd = 1'b1;
      cmd_q.push_back('{1'b1, {10'b0, read_addr_in} * 27'd8});
    end
    if (read_data_valid_out | exp_rv) begin
      chk("rvalid", read_data_valid_out, exp_rv);
      if (exp_rv) chk("rdata", read_data_out, exp_rd);
    end
    exp_rv = app_rd_data_valid_in;
    exp_rd = app_rd_data_in;
    if (app_rd_data_valid_in) tb_out--;
    s_wincr = write_incr_out; s_wcal = write_calib_out;
    s_rincr = read_incr_out;  s_rcal = read_calib_out;
  endtask

  // Step past the posedge, advance the counters, drive the next inputs.
  task automatic commit();
    @(posedge clk_in);
    #1;
    if (s_wcal) wr_cnt = WR_BASE + 17'd1; else if (s_wincr) wr_cnt = wr_cnt + 17'd1;
    if (s_rcal) rd_cnt = RD_BASE + 17'd1; else if (s_rincr) rd_cnt = rd_cnt + 17'd1;
    if (rand_in) begin
      calib_complete_in = ($urandom_range(0, 9) != 0);
      write_valid_in    = ($urandom_range(0, 2) != 0);
      read_valid_in     = ($urandom_range(0, 2) != 0);
      write_tuser_in    = ($urandom_range(0, 7) == 0);
      read_tuser_in     = ($urandom_range(0, 7) == 0);
      write_data_in     = {$urandom, $urandom, $urandom, $urandom};
    end
    if (mig_auto) begin
      app_rdy_in           = ($urandom_range(0, 3) != 0);
      app_wdf_rdy_in       = ($urandom_range(0, 3) != 0);
      app_rd_data_valid_in = (tb_out > 0) && ($urandom_range(0, 2) != 0);
      app_rd_data_in       = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    int   g[$];
    int   grants;
    logic got, rd_seen, chk_x28;
    logic [127:0] d;
    rst_in = 1'b1; calib_complete_in = 1'b0;
    write_valid_in = 1'b0; write_tuser_in = 1'b0; write_data_in = '0;
    read_valid_in = 1'b0; read_tuser_in = 1'b0;
    app_rdy_in = 1'b0; app_wdf_rdy_in = 1'b0;
    app_rd_data_valid_in = 1'b0; app_rd_data_in = '0;
    rand_in = 1'b0; mig_auto = 1'b0;
    wr_cnt = WR_BASE; rd_cnt = RD_BASE;
    clear_model();
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Reset state
    sample();
    chk("rst_en", app_en_out, 0);
    chk("rst_wren", app_wdf_wren_out, 0);
    chk("rst_rvalid", read_data_valid_out, 0);
    chk("rst_addr", app_addr_out, 0);
    chk("rst_cmd", app_cmd_out, 0);
    commit();

    // Calibration gating, then a framed write with a stalled command
    write_valid_in = 1'b1; write_tuser_in = 1'b1;
    write_data_in = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("nocal_wrdy", write_ready_out, 0);
      chk("nocal_en", app_en_out, 0);
      commit();
    end
    calib_complete_in = 1'b1; app_rdy_in = 1'b0; app_wdf_rdy_in = 1'b1;
    sample();
    chk("cal_wrdy", write_ready_out, 1);
    chk("cal_wcal", write_calib_out, 1);
    chk("cal_wincr", write_incr_out, 1);
    commit();
    write_valid_in = 1'b0; write_tuser_in = 1'b0;
    sample();
    chk("w_en", app_en_out, 1);
    chk("w_addr", app_addr_out, 0);
    chk("w_cmd", app_cmd_out, 3'b000);
    chk("w_wren", app_wdf_wren_out, 1);
    commit();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("stall_wren", app_wdf_wren_out, 0);
      chk("stall_en", app_en_out, 1);
      commit();
    end
    app_rdy_in = 1'b1;
    sample();
    commit();
    sample();
    chk("w_idle_en", app_en_out, 0);
    commit();

    // Both sides valid: grants alternate; read counter at 5
    rd_cnt = 17'h5;
    write_valid_in = 1'b1; read_valid_in = 1'b1;
    rd_seen = 1'b0; chk_x28 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      write_data_in = {$urandom, $urandom, $urandom, $urandom};
      sample();
      if (chk_x28) begin
        chk("raddr_x28", app_addr_out, 27'h28);
        chk("rcmd", app_cmd_out, 3'b001);
        chk_x28 = 1'b0;
      end
      if (ev_wacc) g.push_back(0);
      if (ev_racc) begin
        g.push_back(1);
        if (!rd_seen) begin rd_seen = 1'b1; chk_x28 = 1'b1; end
      end
      commit();
    end
    chk("alt_count", g.size() >= 4, 1);
    for (int i = 1; i < g.size(); i++) chk("alternate", g[i] != g[i-1], 1);
    write_valid_in = 1'b0; read_valid_in = 1'b0;
    repeat (3) begin sample(); commit(); end

    // Reset mid-write: command accepted, data still pending
    write_valid_in = 1'b1; app_wdf_rdy_in = 1'b0; app_rdy_in = 1'b1;
    write_data_in = {$urandom, $urandom, $urandom, $urandom};
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      sample();
      got = ev_wacc;
      commit();
    end
    chk("mid_accept", got, 1);
    write_valid_in = 1'b0;
    sample();
    commit();
    sample();
    chk("mid_en", app_en_out, 0);
    chk("mid_wren", app_wdf_wren_out, 1);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    clear_model();
    app_wdf_rdy_in = 1'b1;
    sample();
    chk("mrst_en", app_en_out, 0);
    chk("mrst_wren", app_wdf_wren_out, 0);
    commit();

    // Credit limit: 16 reads with no returns, then one return frees a slot
    read_valid_in = 1'b1;
    grants = 0;
    for (int i = 0; i < 60 && grants < MAXO; i++) begin
      sample();
      if (ev_racc) grants++;
      commit();
    end
    chk("grants16", grants, MAXO);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("cred_block", read_ready_out, 0);
      commit();
    end
    d = 128'h0F0F_1234_5678_9ABC_DEF0_0000_FFFF_A5A5;
    app_rd_data_valid_in = 1'b1; app_rd_data_in = d;
    sample();
    chk("cred_still", read_ready_out, 0);
    commit();
    app_rd_data_valid_in = 1'b0;
    sample();
    chk("ret_valid", read_data_valid_out, 1);
    chk("ret_data", read_data_out, d);
    chk("read17", read_ready_out, 1);
    commit();

    // Randomized traffic
    rand_in = 1'b1; mig_auto = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      sample();
      commit();
    end
    rand_in = 1'b0;
    write_valid_in = 1'b0; read_valid_in = 1'b0;
    for (int i = 0; i < 300 && (tb_out > 0 || cmd_q.size() > 0 || wd_q.size() > 0); i++) begin
      sample();
      commit();
    end
    chk("drain_out", tb_out, 0);
    chk("drain_q", cmd_q.size() + wd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mig_cmd_sequencer.md
Name: mig_cmd_sequencer

Overview:
- Sits between the pixel-side stream logic and the MIG user interface (UI).
- Accepts 128-bit write beats and read requests, arbitrates them, and issues one MIG UI command per transaction, using addresses from two external word-address counters (one write, one read).
- Returns MIG read data as a valid-only stream.
- Bounds in-flight reads so the downstream read FIFO never overflows.

Parameters:
WORD_ADDR_W, 17, width of the word address from each external counter
APP_ADDR_W, 27, MIG app_addr width
ADDR_SHIFT, 3, left shift from word address to app_addr (8 DDR columns per 128-bit word)
MAX_OUTSTANDING, 16, maximum issued-but-unreturned reads; must be ≤ downstream FIFO depth

Ports:
clk_in  in  1  UI clock
rst_in  in  1  synchronous, active-high reset
calib_complete_in  in  1  MIG init_calib_complete; no commands are issued while low
write_valid_in  in  1  write beat valid
write_ready_out  out  1  write beat accepted when valid&ready
write_data_in  in  128  write beat data
write_tuser_in  in  1  first beat of frame
write_addr_in  in  WORD_ADDR_W  current write word address from counter (combinational)
write_incr_out  out  1  advance write counter
write_calib_out  out  1  restart write counter at base
read_valid_in  in  1  read request valid
read_ready_out  out  1  read request accepted when valid&ready
read_tuser_in  in  1  first request of frame
read_addr_in  in  WORD_ADDR_W  current read word address
read_incr_out  out  1  advance read counter
read_calib_out  out  1  restart read counter
app_addr_out  out  APP_ADDR_W  MIG app_addr
app_cmd_out  out  3  MIG app_cmd (000 write, 001 read)
app_en_out  out  1  MIG app_en
app_rdy_in  in  1  MIG app_rdy
app_wdf_data_out  out  128  MIG write data
app_wdf_wren_out  out  1  MIG app_wdf_wren
app_wdf_end_out  out  1  MIG app_wdf_end (equals app_wdf_wren_out)
app_wdf_rdy_in  in  1  MIG app_wdf_rdy
app_rd_data_in  in  128  MIG read data
app_rd_data_valid_in  in  1  MIG read data valid
read_data_out  out  128  returned read word
read_data_valid_out  out  1  returned read word valid; no backpressure

Behaviour:
- Reset values: state=IDLE, all *_out valid/enable/strobe signals 0, outstanding=0, last_grant=READ (so write wins the first tie), data and address registers 0.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - A side is eligible when calib_complete_in=1 and its valid is high.
  - Read is additionally eligible only if outstanding < MAX_OUTSTANDING.
  - If both sides are eligible, grant the side opposite last_grant (round robin).
  - write_ready_out / read_ready_out are combinational and high only for the granted side in IDLE.
- On acceptance, in the same cycle:
  - Pulse the side's *_incr_out.
  - Pulse *_calib_out if tuser=1.
  - When calib is pulsed, the counter presents its base address combinationally; the sequencer latches *_addr_in in that same cycle.
  - Latch data, and latch app_addr = zero-extended addr << ADDR_SHIFT.
  - Update last_grant and move to WRITE or READ.
- WRITE:
  - app_en_out = !cmd_done; app_wdf_wren_out = !data_done; app_cmd_out = 000.
  - cmd_done is set on app_en&app_rdy; data_done is set on wren&wdf_rdy. Either may complete first, or both in the same cycle.
  - Return to IDLE in the cycle after both are done; clear the flags.
- READ:
  - app_en_out=1, app_cmd_out=001.
  - On app_rdy_in: outstanding +1, go to IDLE.
- Read return path:
  - read_data_out/valid_out register app_rd_data/valid with 1-cycle latency.
  - Outstanding decrements on app_rd_data_valid_in.
  - Simultaneous issue and return in the same cycle: outstanding unchanged.
- Throughput: minimum 2 cycles per transaction (IDLE + one issue cycle).
- Outputs stay stable while stalled on app_rdy/app_wdf_rdy.
- calib_complete_in falling mid-transaction does not abort it; it only blocks new grants.
- rst_in mid-transaction abandons it, returns to IDLE, and zeroes outstanding.
- outstanding width is $clog2(MAX_OUTSTANDING+1); it never exceeds MAX_OUTSTANDING.

Decomposition:
- Shared package mig_pkg: MIG_CMD_WRITE=3'b000, MIG_CMD_READ=3'b001, MIG_DATA_W=128, and the seq_state_t enum {IDLE, WRITE, READ}.
- One natural sub-module: mig_read_credit, the outstanding counter with can_issue output.

Test Plan:
- Hold calib_complete_in=0 with write_valid_in=1 → write_ready_out stays 0 and app_en_out stays 0; raise calib_complete_in → beat accepted the next cycle.
- Write beat with tuser=1 and counter base 0x0 → write_calib_out=1 and write_incr_out=1 in the accept cycle; next cycle app_addr_out=0x0, app_cmd_out=000.
- app_rdy_in held low for 3 cycles while app_wdf_rdy_in=1 → wdf accepted on the first cycle and app_wdf_wren_out drops; app_en_out is held with stable address until app_rdy_in rises; IDLE follows.
- Write and read valid continuously → grants alternate W,R,W,R; read addr 0x5 yields app_addr_out=0x28.
- Issue 16 reads with no returns (MAX_OUTSTANDING=16) → read_ready_out stays 0; one app_rd_data_valid_in pulse → read_data_valid_out one cycle later and a 17th read is granted.
- Assert rst_in during WRITE with cmd accepted but data not accepted → next cycle state is IDLE, all enables are 0, outstanding=0.
